// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry add/subtract unit: STAGES carry segments of CHUNK bits,
// valid/ready handshake on both sides, fixed latency of STAGES cycles.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH exactly");
    end

    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             w_advance;

    // A full output register only blocks the pipe while the consumer refuses it.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO  = k * CHUNK;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]      w_a_src;
        logic [REM-1:0]      w_b_src;
        logic                w_c_src;
        logic                w_sub_src;
        logic                w_v_src;
        logic [CHUNK:0]      w_sum;
        logic [LO+CHUNK-1:0] w_s_next;

        assign w_sum = {1'b0, w_a_src[CHUNK-1:0]}
                     + {1'b0, w_b_src[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, w_c_src};

        if (k == 0) begin : g_src
            // Subtraction is folded into the operands here: A + ~B + ~Cin.
            assign w_a_src   = A;
            assign w_b_src   = Sub ? ~B : B;
            assign w_c_src   = Cin ^ Sub;
            assign w_sub_src = Sub;
            assign w_v_src   = in_valid;
            assign w_s_next  = w_sum[CHUNK-1:0];
        end else begin : g_src
            assign w_a_src   = g_stg[k-1].g_reg.r_a;
            assign w_b_src   = g_stg[k-1].g_reg.r_b;
            assign w_c_src   = g_stg[k-1].g_reg.r_c;
            assign w_sub_src = g_stg[k-1].g_reg.r_sub;
            assign w_v_src   = g_stg[k-1].g_reg.r_v;
            assign w_s_next  = {w_sum[CHUNK-1:0], g_stg[k-1].g_reg.r_s};
        end

        if (k < LAST) begin : g_reg
            logic [REM-CHUNK-1:0] r_a;
            logic [REM-CHUNK-1:0] r_b;
            logic [LO+CHUNK-1:0]  r_s;
            logic                 r_c;
            logic                 r_sub;
            logic                 r_v;

            // Segment register: unresolved upper operands, resolved lower sum, carry.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_s   <= '0;
                    r_c   <= 1'b0;
                    r_sub <= 1'b0;
                    r_v   <= 1'b0;
                end else if (w_advance) begin
                    r_a   <= w_a_src[REM-1:CHUNK];
                    r_b   <= w_b_src[REM-1:CHUNK];
                    r_s   <= w_s_next;
                    r_c   <= w_sum[CHUNK];
                    r_sub <= w_sub_src;
                    r_v   <= w_v_src;
                end
            end
        end
    end

    logic w_last_cout_raw;
    logic w_last_c_msb;

    assign w_last_cout_raw = g_stg[LAST].w_sum[CHUNK];
    assign w_last_c_msb    = g_stg[LAST].w_a_src[CHUNK-1]
                           ^ g_stg[LAST].w_b_src[CHUNK-1]
                           ^ g_stg[LAST].w_sum[CHUNK-1];

    // Final segment lands directly in the output register; borrow is the inverted carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= g_stg[LAST].w_v_src;
            r_s         <= g_stg[LAST].w_s_next;
            r_cout      <= w_last_cout_raw ^ g_stg[LAST].w_sub_src;
            r_ovf       <= w_last_c_msb ^ w_last_cout_raw;
        end
    end

    assign out_valid = r_out_valid;
    assign S         = r_s;
    assign Cout      = r_cout;
    assign Ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: three instances (16/4, 8/1, 32/8) checked
// against an integer-arithmetic reference model, including latency and stall accounting.
module tb_pipelined_adder;
    localparam int N = 3;

    function automatic int wof(int g);
        case (g)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int sof(int g);
        case (g)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          cyc;
        int          stl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid[N];
    logic        in_ready[N];
    logic        out_valid[N];
    logic        out_ready[N];
    logic        cin[N];
    logic        sub[N];
    logic        cout[N];
    logic        ovf[N];
    logic [31:0] a[N];
    logic [31:0] b[N];
    logic [31:0] s[N];

    exp_t q[N][$];
    int   stl[N];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = wof(g);
        logic [W-1:0] w_s;
        pipelined_adder #(.WIDTH(W), .STAGES(sof(g))) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .A        (a[g][W-1:0]),
            .B        (b[g][W-1:0]),
            .Cin      (cin[g]),
            .Sub      (sub[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .S        (w_s),
            .Cout     (cout[g]),
            .Ovf      (ovf[g])
        );
        assign s[g] = 32'(w_s);
    end

    function automatic void check(string name, longint act, longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    // Plain integer arithmetic: unsigned for S/Cout, signed range test for Ovf.
    function automatic exp_t ref_model(logic [31:0] ai, logic [31:0] bi, logic ci, logic si, int w);
        exp_t   e;
        longint m, half, ua, ub, sa, sb, t, r;
        m    = (longint'(1) << w) - 64'sd1;
        half = longint'(1) << (w - 1);
        ua   = longint'(ai) & m;
        ub   = longint'(bi) & m;
        sa   = (ua >= half) ? ua - (m + 64'sd1) : ua;
        sb   = (ub >= half) ? ub - (m + 64'sd1) : ub;
        if (!si) begin
            t   = ua + ub + longint'(ci);
            e.c = (t > m);
            r   = sa + sb + longint'(ci);
        end else begin
            t   = ua - ub - longint'(ci);
            e.c = (ua < ub + longint'(ci));
            r   = sa - sb - longint'(ci);
        end
        e.s   = 32'(t & m);
        e.o   = (r >= half) || (r < -half);
        e.cyc = 0;
        e.stl = 0;
        return e;
    endfunction

    // Monitor: pop/compare delivered results, push accepted operations, count stall cycles.
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < N; g++) begin
            if (rst) begin
                q[g].delete();
            end else begin
                if (out_valid[g] && out_ready[g]) begin
                    if (q[g].size() == 0) begin
                        check($sformatf("dut%0d_result_without_op", g), longint'(out_valid[g]), 0);
                    end else begin
                        e = q[g].pop_front();
                        check($sformatf("dut%0d_S", g), longint'(s[g]), longint'(e.s));
                        check($sformatf("dut%0d_Cout", g), longint'(cout[g]), longint'(e.c));
                        check($sformatf("dut%0d_Ovf", g), longint'(ovf[g]), longint'(e.o));
                        check($sformatf("dut%0d_latency", g), longint'(cyc - e.cyc),
                              longint'(sof(g) + stl[g] - e.stl));
                    end
                end
                if (in_valid[g] && in_ready[g]) begin
                    e     = ref_model(a[g], b[g], cin[g], sub[g], wof(g));
                    e.cyc = cyc;
                    e.stl = stl[g];
                    q[g].push_back(e);
                end
                if (!in_ready[g]) stl[g]++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(logic v, logic [31:0] av, logic [31:0] bv, logic cv, logic sv);
        in_valid[0] = v;
        a[0]        = av;
        b[0]        = bv;
        cin[0]      = cv;
        sub[0]      = sv;
    endtask

    initial begin
        logic [15:0] pat;
        logic [31:0] held;
        int          nxt;
        int          seen;
        for (int g = 0; g < N; g++) begin
            in_valid[g] = 1'b0; out_ready[g] = 1'b1;
            a[g] = 32'd0; b[g] = 32'd0; cin[g] = 1'b0; sub[g] = 1'b0;
            stl[g] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            check($sformatf("dut%0d_reset_out_valid", g), longint'(out_valid[g]), 0);
            check($sformatf("dut%0d_reset_S", g), longint'(s[g]), 0);
            check($sformatf("dut%0d_reset_Cout", g), longint'(cout[g]), 0);
            check($sformatf("dut%0d_reset_Ovf", g), longint'(ovf[g]), 0);
            check($sformatf("dut%0d_reset_in_ready", g), longint'(in_ready[g]), 1);
        end

        // Full carry ripple, then the two subtract cases.
        step();
        drive0(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0); step();
        drive0(1'b1, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1); step();
        drive0(1'b1, 32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1); step();
        drive0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (8) step();

        // Back-to-back stream: A=B=i, Cin=1.
        pat = 16'h0;
        for (int i = 0; i < 16; i++) begin
            if (i < 8) drive0(1'b1, 32'(i), 32'(i), 1'b1, 1'b0);
            else       drive0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            pat[i] = out_valid[0];
            if (i < 8) check("stream_in_ready", longint'(in_ready[0]), 1);
            step();
        end
        check("stream_out_valid_pattern", longint'(pat), longint'(16'h0FF0));

        // Consumer stall for three cycles in the middle of a 6-op stream.
        nxt  = 0;
        held = 32'h0;
        for (int i = 0; i < 24; i++) begin
            out_ready[0] = !(i >= 4 && i < 7);
            drive0(nxt < 6, 32'(100 + nxt), 32'(3 * nxt), nxt[0], 1'b0);
            @(negedge clk);
            if (i == 4) held = s[0];
            if (i >= 4 && i < 7) begin
                check("stall_in_ready", longint'(in_ready[0]), 0);
                check("stall_out_valid", longint'(out_valid[0]), 1);
            end
            if (i == 5 || i == 6) check("stall_S_held", longint'(s[0]), longint'(held));
            if (in_valid[0] && in_ready[0]) nxt++;
            step();
        end
        check("stall_ops_accepted", longint'(nxt), 6);
        out_ready[0] = 1'b1;
        drive0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Bubbles: every other slot empty.
        pat = 16'h0;
        for (int i = 0; i < 16; i++) begin
            drive0((i < 8) && (i % 2 == 0), 32'(i * 7 + 1), 32'd5, 1'b0, i[1]);
            @(negedge clk);
            pat[i] = out_valid[0];
            step();
        end
        check("bubble_out_valid_pattern", longint'(pat), longint'(16'h0550));

        // Reset mid-stream discards in-flight work.
        for (int i = 0; i < 6; i++) begin
            drive0(1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        @(negedge clk);
        check("prereset_out_valid", longint'(out_valid[0]), 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive0(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("midreset_out_valid", longint'(out_valid[0]), 0);
        check("midreset_S", longint'(s[0]), 0);
        check("midreset_Cout", longint'(cout[0]), 0);
        check("midreset_Ovf", longint'(ovf[0]), 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        check("postreset_stale_results", longint'(seen), 0);

        // Random traffic on all three parameterisations at once.
        for (int i = 0; i < 400; i++) begin
            for (int g = 0; g < N; g++) begin
                in_valid[g]  = ($urandom_range(0, 3) != 0);
                out_ready[g] = ($urandom_range(0, 9) < 7);
                a[g]   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom();
                b[g]   = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom();
                cin[g] = 1'($urandom_range(0, 1));
                sub[g] = 1'($urandom_range(0, 1));
            end
            step();
        end
        for (int g = 0; g < N; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b1;
        end
        repeat (20) step();
        for (int g = 0; g < N; g++) begin
            check($sformatf("dut%0d_results_outstanding", g), longint'(q[g].size()), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
